amm_rd_master: RTL and testbench
================================

Name: amm_rd_master

Overview:
- Avalon-MM pipelined read master. It sits directly upstream of the Avalon-MM read slave: it drives address/read and consumes readdata/readdatavalid/waitrequest.
- Accepts a command (start word address, word count) and issues sequential word reads. Returned words are buffered and emitted in order on a valid/ready stream with a last flag.
- It is the fetch stage of the byte_inc datapath.

Parameters:
- DATA_WIDTH, 64, Avalon readdata width and output stream width.
- ADDR_WIDTH, 10, Avalon word address width.
- LEN_WIDTH, 11, command length width (max words per command = 2**LEN_WIDTH-1).
- FIFO_DEPTH, 8, response buffer depth in words; must be a power of 2, >=2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_addr_i  in  ADDR_WIDTH  first word address.
- cmd_len_i  in  LEN_WIDTH  number of words to read.
- amm_address_o  out  ADDR_WIDTH  Avalon address.
- amm_read_o  out  1  Avalon read request.
- amm_readdata_i  in  DATA_WIDTH  Avalon read data.
- amm_readdatavalid_i  in  1  Avalon read data valid.
- amm_waitrequest_i  in  1  Avalon waitrequest.
- data_o  out  DATA_WIDTH  output word.
- data_valid_o  out  1  output word valid.
- data_last_o  out  1  final word of current command.
- data_ready_i  in  1  downstream ready.
- busy_o  out  1  command in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0, async): state=IDLE; cmd_ready_o=1, amm_read_o=0, amm_address_o=0, data_valid_o=0, data_last_o=0, data_o=0, busy_o=0; counters and FIFO cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready_o=1.
  - On accept with cmd_len_i!=0: latch addr and len, set issue_left=len and recv_left=len, go to ISSUE next cycle.
  - On accept with cmd_len_i==0: discard; stay in IDLE; no bus activity; no output.
- ISSUE:
  - cmd_ready_o=0.
  - amm_read_o asserts when credit is available: inflight + fifo_count < FIFO_DEPTH. inflight counts accepted-but-not-returned reads.
  - Once asserted, amm_read_o and amm_address_o stay stable until accepted (amm_read_o & !amm_waitrequest_i). Read is never withdrawn.
  - On accept: address+1 (wraps modulo 2**ADDR_WIDTH), issue_left-1, inflight+1.
  - When the accepted read is the last one (issue_left==1): go to DRAIN, with amm_read_o=0 from the next cycle.
  - Back-to-back reads are allowed: one accept per cycle when waitrequest=0 and credit is available.
- DRAIN:
  - No reads issued.
  - Return to IDLE in the cycle after the last word (data_last_o=1) is popped by data_ready_i.
  - cmd_ready_o=1 from that IDLE cycle.
- Response path, every state:
  - amm_readdatavalid_i pushes {last, readdata} into the FIFO; last = (recv_left==1); recv_left-1; inflight-1.
  - A push and an accept in the same cycle leave inflight unchanged.
  - The credit rule guarantees the FIFO never overflows. readdatavalid is never backpressured. Overflow is an assertion failure.
- Output stream:
  - Show-ahead FIFO: data_valid_o = !empty; data_o and data_last_o are the FIFO head.
  - Pop on data_valid_o & data_ready_i. Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Stream latency: a word returned in cycle N is visible on data_o in cycle N+1.
  - Words are emitted in address order; exactly len words per command.
- data_valid_o, data_o and data_last_o are stable while data_valid_o=1 and data_ready_i=0.
- Reset mid-command: everything returns to reset values immediately. Responses still outstanding from the slave are not tracked; the slave is reset by the same rst_n.
- readdatavalid with inflight==0 is illegal (assertion).

Decomposition:
- Package amm_rd_master_pkg:
  - state_t enum {IDLE, ISSUE, DRAIN}.
  - localparam function for counter width: $clog2(FIFO_DEPTH)+1.
- Sub-module amm_rd_fifo:
  - Synchronous show-ahead FIFO with width DATA_WIDTH+1 and depth FIFO_DEPTH.
  - Ports: push, pop, wdata, rdata, empty, full, count.
  - Same clock and async active-low reset as the parent.

Test Plan:
- Basic: cmd addr=0x010, len=4, waitrequest=0, data_ready=1, slave latency 2 -> reads at 0x010..0x013 on 4 consecutive cycles; 4 words out in order, data_last_o only on 4th; cmd_ready_o=1 the cycle after last pop.
- Waitrequest: waitrequest high for 3 cycles on 2nd read of len=3 -> address 0x011 and read held stable for 3 cycles; exactly 3 accepts total, no duplicate addresses.
- Backpressure/credit: len=20, data_ready_i=0, FIFO_DEPTH=8 -> read issues stop at 8 outstanding+buffered; no overflow. Release ready -> all 20 words delivered in order, last on word 20.
- Boundary: len=0 -> accepted, no amm_read_o, no data_valid_o, busy_o stays 0. Addr=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-op: assert rst_n=0 after 2 of 6 reads are accepted -> all outputs at reset values asynchronously. A new cmd len=2 then completes normally.
- Random: random waitrequest, latency 1-5 and data_ready over 100 commands -> scoreboard matches memory model; at most one last per command; amm_read_o never withdrawn while waitrequest=1.

Source files
------------

// File: rtl/amm_rd_master_pkg.sv
// Shared types and helpers for the Avalon-MM read master and its response buffer.
package amm_rd_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/amm_rd_master_if.sv
// Command, Avalon-MM read and output stream signals of the read master.
interface amm_rd_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic [ADDR_WIDTH-1:0] amm_address_o;
  logic                  amm_read_o;
  logic [DATA_WIDTH-1:0] amm_readdata_i;
  logic                  amm_readdatavalid_i;
  logic                  amm_waitrequest_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  data_last_o;
  logic                  data_ready_i;
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i,
    input  amm_readdata_i, amm_readdatavalid_i, amm_waitrequest_i,
    input  data_ready_i,
    output cmd_ready_o, amm_address_o, amm_read_o,
    output data_o, data_valid_o, data_last_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i,
    output amm_readdata_i, amm_readdatavalid_i, amm_waitrequest_i,
    output data_ready_i,
    input  cmd_ready_o, amm_address_o, amm_read_o,
    input  data_o, data_valid_o, data_last_o, busy_o
  );
endinterface

// File: rtl/amm_rd_fifo.sv
// Show-ahead response buffer: the head entry is always visible on rdata.
// Push and pop may coincide, including when full.
module amm_rd_fifo
  import amm_rd_master_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        empty,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count
);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/amm_rd_master_chk.sv
// Protocol and buffering invariants of the read master, checked in simulation.
module amm_rd_master_chk #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_W      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  push,
  input logic                  pop,
  input logic                  full,
  input logic                  read,
  input logic                  waitrequest,
  input logic [ADDR_WIDTH-1:0] address,
  input logic [CNT_W-1:0]      inflight
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

  a_rdv_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (inflight != '0));

  a_read_held: assert property (@(posedge clk) disable iff (!rst_n)
    (read && waitrequest) |=> (read && $stable(address)));

endmodule

// File: rtl/amm_rd_master.sv
// Avalon-MM pipelined read master: issues sequential word reads under a
// buffer-credit limit and streams the returned words out in order.
module amm_rd_master
  import amm_rd_master_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  amm_rd_master_if.master  bus
);
  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_read;
  logic                  w_read_nxt;
  logic [LEN_WIDTH-1:0]  r_issue_left;
  logic [LEN_WIDTH-1:0]  w_issue_left_nxt;
  logic [LEN_WIDTH-1:0]  r_recv_left;
  logic [LEN_WIDTH-1:0]  w_recv_left_nxt;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      w_inflight_nxt;
  logic                  r_cmd_ready;
  logic                  r_busy;

  logic                  w_cmd_acc;
  logic                  w_rd_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_empty;
  logic                  w_full;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [DATA_WIDTH:0]   w_fifo_wdata;
  logic [DATA_WIDTH:0]   w_fifo_rdata;

  assign w_cmd_acc = bus.cmd_valid_i & r_cmd_ready;
  assign w_rd_acc  = r_read & ~bus.amm_waitrequest_i;
  assign w_push    = bus.amm_readdatavalid_i;
  assign w_pop     = ~w_empty & bus.data_ready_i;

  // Credit is judged on next-cycle occupancy so a registered read never overcommits the buffer.
  assign w_count_nxt    = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_inflight_nxt = r_inflight + CNT_W'(w_rd_acc) - CNT_W'(w_push);
  assign w_credit       = (SUM_W'(w_inflight_nxt) + SUM_W'(w_count_nxt)) < SUM_W'(FIFO_DEPTH);

  assign w_fifo_wdata = {(r_recv_left == LEN_WIDTH'(1)), bus.amm_readdata_i};

  // Next-state and next-register values
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_read_nxt       = r_read;
    w_issue_left_nxt = r_issue_left;
    if (w_push && (r_recv_left != '0)) begin
      w_recv_left_nxt = r_recv_left - LEN_WIDTH'(1);
    end else begin
      w_recv_left_nxt = r_recv_left;
    end
    case (r_state)
      IDLE: begin
        w_read_nxt = 1'b0;
        if (w_cmd_acc && (bus.cmd_len_i != '0)) begin
          w_state_nxt      = ISSUE;
          w_addr_nxt       = bus.cmd_addr_i;
          w_issue_left_nxt = bus.cmd_len_i;
          w_recv_left_nxt  = bus.cmd_len_i;
          w_read_nxt       = w_credit;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (w_rd_acc) begin
          w_addr_nxt       = r_addr + ADDR_WIDTH'(1);
          w_issue_left_nxt = r_issue_left - LEN_WIDTH'(1);
        end else begin
          w_addr_nxt = r_addr;
        end
        if (r_read && bus.amm_waitrequest_i) begin
          w_read_nxt = 1'b1;
        end else if (w_rd_acc && (r_issue_left == LEN_WIDTH'(1))) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = DRAIN;
        end else begin
          w_read_nxt = w_credit;
        end
      end
      DRAIN: begin
        w_read_nxt = 1'b0;
        if (w_pop && w_fifo_rdata[DATA_WIDTH]) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_read_nxt  = 1'b0;
      end
    endcase
  end

  // State, address, request and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_read       <= 1'b0;
      r_issue_left <= '0;
      r_recv_left  <= '0;
      r_inflight   <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_read       <= w_read_nxt;
      r_issue_left <= w_issue_left_nxt;
      r_recv_left  <= w_recv_left_nxt;
      r_inflight   <= w_inflight_nxt;
      r_cmd_ready  <= (w_state_nxt == IDLE);
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  amm_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_fifo_wdata),
    .rdata (w_fifo_rdata),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  amm_rd_master_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_push),
    .pop         (w_pop),
    .full        (w_full),
    .read        (r_read),
    .waitrequest (bus.amm_waitrequest_i),
    .address     (r_addr),
    .inflight    (r_inflight)
  );

  assign bus.cmd_ready_o   = r_cmd_ready;
  assign bus.busy_o        = r_busy;
  assign bus.amm_address_o = r_addr;
  assign bus.amm_read_o    = r_read;
  assign bus.data_valid_o  = ~w_empty;
  assign bus.data_o        = w_empty ? '0 : w_fifo_rdata[DATA_WIDTH-1:0];
  assign bus.data_last_o   = ~w_empty & w_fifo_rdata[DATA_WIDTH];

endmodule

// File: tb/tb_amm_rd_master.sv
// Randomized bench for amm_rd_master: a memory-backed slave with in-order
// responses and a word-level expectation queue built from each command.
module tb_amm_rd_master;
  import amm_rd_master_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int DEPTH = 8;
  localparam int MEMSZ = 1024;

  typedef logic [127:0] v_t;

  logic clk;
  logic rst_n;

  amm_rd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  amm_rd_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests;
  int            n_fail;
  int            cyc;
  logic [DW-1:0] mem [MEMSZ];
  logic [DW:0]   exp_q [$];
  int            exp_addr_q [$];
  logic [DW-1:0] rsp_data_q [$];
  int            rsp_due_q [$];
  int            last_due;
  int            acc_done, ret_done, pop_done;
  int            first_acc_cyc, last_acc_cyc;
  int            wr_pct, rdy_pct, lat_min, lat_max;
  int            stall_addr, stall_cnt, watch_addr, watch_cnt;
  logic          cmd_seen, exp_ready_next, busy_seen;
  logic          p_valid, p_ready, p_last, p_read, p_wr;
  logic [DW-1:0] p_data;
  logic [AW-1:0] p_addr;

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_prev();
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_read = 1'b0; p_wr = 1'b0;
    p_data = '0; p_addr = '0; exp_ready_next = 1'b0;
  endtask

  // Observe the cycle at the falling edge; everything seen here happens at the next rising edge.
  task automatic observe();
    int            lat;
    int            due;
    logic [AW-1:0] ea;
    logic [DW:0]   e;
    chk("valid", v_t'(bus.data_valid_o), v_t'((ret_done - pop_done) > 0));
    chk("credit", v_t'(bus.amm_read_o && ((acc_done - pop_done) >= DEPTH)), v_t'(0));
    if (p_read && p_wr) begin
      chk("rd_hold", v_t'({bus.amm_read_o, bus.amm_address_o}), v_t'({1'b1, p_addr}));
    end
    if (p_valid && !p_ready) begin
      chk("out_hold", v_t'({bus.data_valid_o, bus.data_last_o, bus.data_o}), v_t'({1'b1, p_last, p_data}));
    end
    if (exp_ready_next) begin
      chk("ready_after_last", v_t'({bus.cmd_ready_o, bus.busy_o}), v_t'(2'b10));
      exp_ready_next = 1'b0;
    end
    busy_seen = busy_seen | bus.busy_o;
    if (bus.amm_read_o && (bus.amm_address_o == AW'(watch_addr))) watch_cnt++;
    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
      cmd_seen = 1'b1;
      for (int i = 0; i < int'(bus.cmd_len_i); i++) begin
        exp_addr_q.push_back((int'(bus.cmd_addr_i) + i) % MEMSZ);
        exp_q.push_back({(i == int'(bus.cmd_len_i) - 1), mem[(int'(bus.cmd_addr_i) + i) % MEMSZ]});
      end
    end
    if (bus.amm_read_o && !bus.amm_waitrequest_i) begin
      ea = 'x;
      if (exp_addr_q.size() > 0) ea = AW'(exp_addr_q.pop_front());
      chk("rd_addr", v_t'(bus.amm_address_o), v_t'(ea));
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      rsp_data_q.push_back(mem[bus.amm_address_o]);
      rsp_due_q.push_back(due);
      acc_done++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (bus.amm_readdatavalid_i) ret_done++;
    if (bus.data_valid_o && bus.data_ready_i) begin
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("word", v_t'({bus.data_last_o, bus.data_o}), v_t'(e));
      if (e[DW] === 1'b1) exp_ready_next = 1'b1;
      pop_done++;
    end
    p_valid = bus.data_valid_o; p_ready = bus.data_ready_i; p_last = bus.data_last_o;
    p_data = bus.data_o; p_read = bus.amm_read_o; p_wr = bus.amm_waitrequest_i;
    p_addr = bus.amm_address_o;
  endtask

  // Slave responses in order, waitrequest and downstream ready for the new cycle.
  task automatic drive();
    int tmp;
    if ((rsp_due_q.size() > 0) && (rsp_due_q[0] <= cyc)) begin
      tmp = rsp_due_q.pop_front();
      bus.amm_readdata_i      = rsp_data_q.pop_front();
      bus.amm_readdatavalid_i = 1'b1;
    end else begin
      bus.amm_readdata_i      = {$urandom, $urandom};
      bus.amm_readdatavalid_i = 1'b0;
    end
    if ((stall_cnt > 0) && bus.amm_read_o && (bus.amm_address_o == AW'(stall_addr))) begin
      bus.amm_waitrequest_i = 1'b1;
      stall_cnt--;
    end else begin
      bus.amm_waitrequest_i = ($urandom_range(99, 0) < wr_pct);
    end
    bus.data_ready_i = ($urandom_range(99, 0) < rdy_pct);
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic send_cmd(input int a, input int l);
    int n;
    n = 0;
    bus.cmd_addr_i  = AW'(a);
    bus.cmd_len_i   = LW'(l);
    bus.cmd_valid_i = 1'b1;
    cmd_seen        = 1'b0;
    while (!cmd_seen && (n < 3000)) begin
      tick();
      n++;
    end
    bus.cmd_valid_i = 1'b0;
    chk("cmd_accept", v_t'(cmd_seen), v_t'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!((exp_q.size() == 0) && bus.cmd_ready_o && !bus.data_valid_o) && (n < budget)) begin
      tick();
      n++;
    end
    chk("idle_timeout", v_t'(n >= budget), v_t'(0));
    chk("reads_done", v_t'(exp_addr_q.size()), v_t'(0));
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_cmd_ready"}, v_t'(bus.cmd_ready_o), v_t'(1));
    chk({pfx, "_read"}, v_t'(bus.amm_read_o), v_t'(0));
    chk({pfx, "_address"}, v_t'(bus.amm_address_o), v_t'(0));
    chk({pfx, "_valid_last"}, v_t'({bus.data_valid_o, bus.data_last_o}), v_t'(0));
    chk({pfx, "_data"}, v_t'(bus.data_o), v_t'(0));
    chk({pfx, "_busy"}, v_t'(bus.busy_o), v_t'(0));
  endtask

  task automatic flush_model();
    exp_q.delete(); exp_addr_q.delete(); rsp_data_q.delete(); rsp_due_q.delete();
    last_due = 0; acc_done = 0; ret_done = 0; pop_done = 0;
    clear_prev();
  endtask

  initial begin
    int acc0;
    int n;
    n_tests = 0; n_fail = 0; cyc = 0;
    wr_pct = 0; rdy_pct = 100; lat_min = 2; lat_max = 2;
    stall_addr = -1; stall_cnt = 0; watch_addr = -1; watch_cnt = 0;
    busy_seen = 1'b0; cmd_seen = 1'b0; first_acc_cyc = -1; last_acc_cyc = -1;
    for (int i = 0; i < MEMSZ; i++) mem[i] = {$urandom, $urandom};
    flush_model();
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
    bus.amm_readdata_i = '0; bus.amm_readdatavalid_i = 1'b0;
    bus.amm_waitrequest_i = 1'b0; bus.data_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive();

    // Basic burst: four back-to-back reads, fixed latency 2
    acc0 = acc_done;
    send_cmd(32'h010, 4);
    wait_idle(200);
    chk("basic_accepts", v_t'(acc_done - acc0), v_t'(4));
    chk("basic_consecutive", v_t'(last_acc_cyc - first_acc_cyc), v_t'(3));

    // Second read held off by three waitrequest cycles
    acc0 = acc_done;
    stall_addr = 32'h011; stall_cnt = 3; watch_addr = 32'h011; watch_cnt = 0;
    send_cmd(32'h010, 3);
    wait_idle(200);
    chk("wr_accepts", v_t'(acc_done - acc0), v_t'(3));
    chk("wr_presented_cycles", v_t'(watch_cnt), v_t'(4));
    watch_addr = -1;

    // Backpressure: issue stops once the buffer credit is used up
    acc0 = acc_done;
    rdy_pct = 0;
    send_cmd(32'h200, 20);
    repeat (40) tick();
    chk("credit_stall", v_t'(acc_done - acc0), v_t'(DEPTH));
    rdy_pct = 100;
    wait_idle(400);
    chk("credit_total", v_t'(acc_done - acc0), v_t'(20));

    // Zero length: accepted, nothing happens
    acc0 = acc_done;
    busy_seen = 1'b0;
    send_cmd(32'h055, 0);
    repeat (10) tick();
    chk("len0_reads", v_t'(acc_done - acc0), v_t'(0));
    chk("len0_busy", v_t'(busy_seen), v_t'(0));

    // Address wrap at the top of the word space
    send_cmd(32'h3FE, 4);
    wait_idle(200);

    // Reset after two of six reads are accepted
    acc0 = acc_done;
    bus.cmd_addr_i = AW'(32'h100); bus.cmd_len_i = LW'(6); bus.cmd_valid_i = 1'b1;
    cmd_seen = 1'b0;
    n = 0;
    while (((acc_done - acc0) < 2) && (n < 100)) begin
      tick();
      if (cmd_seen) bus.cmd_valid_i = 1'b0;
      n++;
    end
    bus.cmd_valid_i = 1'b0;
    chk("mid_two_accepts", v_t'(acc_done - acc0), v_t'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    flush_model();
    bus.amm_readdatavalid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    drive();
    acc0 = acc_done;
    send_cmd(32'h020, 2);
    wait_idle(200);
    chk("post_reset_accepts", v_t'(acc_done - acc0), v_t'(2));

    // Random traffic
    wr_pct = 30; lat_min = 1; lat_max = 5;
    for (int c = 0; c < 100; c++) begin
      case ($urandom_range(2, 0))
        0:       rdy_pct = 25;
        1:       rdy_pct = 60;
        default: rdy_pct = 100;
      endcase
      send_cmd(int'($urandom_range(MEMSZ - 1, 0)), int'($urandom_range(16, 1)));
    end
    rdy_pct = 100;
    wait_idle(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
